alu: RTL and testbench

//  16-bit integer ALU for the a4 processor datapath. Computes z = f(ALUop, X, Y)

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_shifter.sv | 31 +++
 rtl/alu.sv | 62 ++++++
 tb/tb_alu.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the a4 datapath: word width, opcode width and ALU opcode encodings.
// Imported by the ALU and by decoder/control units so encodings live in one place.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 5;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic [OP_W-1:0] OP_ADD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND   = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR    = 5'b00011;
  localparam logic [OP_W-1:0] OP_XOR   = 5'b00100;
  localparam logic [OP_W-1:0] OP_NOT   = 5'b00101;
  localparam logic [OP_W-1:0] OP_NEG   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHL   = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHR   = 5'b01000;
  localparam logic [OP_W-1:0] OP_SRA   = 5'b01001;
  localparam logic [OP_W-1:0] OP_SLT   = 5'b01010;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL   = 5'b01100;
  localparam logic [OP_W-1:0] OP_PASSX = 5'b01101;
  localparam logic [OP_W-1:0] OP_PASSY = 5'b01110;
  localparam logic [OP_W-1:0] OP_LHI   = 5'b01111;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for the ALU: SHL, logical SHR and arithmetic SRA.
// The full-width shift amount is honoured: any amount >= WIDTH saturates.
module alu_shifter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] shl,
  output logic [WIDTH-1:0] shr,
  output logic [WIDTH-1:0] sra
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic                    big;
  logic [SH_W-1:0]         amt;
  logic signed [WIDTH-1:0] xs;
  logic signed [WIDTH-1:0] sra_raw;

  always_comb begin
    big     = (y > WIDTH'(WIDTH - 1));
    amt     = y[SH_W-1:0];
    xs      = x;
    // kept in its own signed variable so >>> is not demoted to a logical shift
    sra_raw = xs >>> amt;
    shl     = big ? '0 : (x << amt);
    shr     = big ? '0 : (x >> amt);
    sra     = big ? {WIDTH{x[WIDTH-1]}} : sra_raw;
  end

endmodule

// File: rtl/alu.sv
// 16-bit integer ALU for the a4 datapath: z = f(ALUop, X, Y), registered one cycle later.
// Reserved opcodes produce zero; synchronous active-high reset clears z.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     ALUop,
  input  logic [WIDTH-1:0]    X,
  input  logic [WIDTH-1:0]    Y,
  output logic [WIDTH-1:0]    z
);

  localparam int unsigned HALF = WIDTH / 2;

  logic [WIDTH-1:0] z_next;
  logic [WIDTH-1:0] shl_r;
  logic [WIDTH-1:0] shr_r;
  logic [WIDTH-1:0] sra_r;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .x   (X),
    .y   (Y),
    .shl (shl_r),
    .shr (shr_r),
    .sra (sra_r)
  );

  always_comb begin
    z_next = '0;
    case (ALUop)
      OP_ADD:   z_next = X + Y;
      OP_SUB:   z_next = X - Y;
      OP_AND:   z_next = X & Y;
      OP_OR:    z_next = X | Y;
      OP_XOR:   z_next = X ^ Y;
      OP_NOT:   z_next = ~X;
      OP_NEG:   z_next = -X;
      OP_SHL:   z_next = shl_r;
      OP_SHR:   z_next = shr_r;
      OP_SRA:   z_next = sra_r;
      OP_SLT:   z_next[0] = ($signed(X) < $signed(Y));
      OP_SLTU:  z_next[0] = (X < Y);
      OP_MUL:   z_next = X * Y;
      OP_PASSX: z_next = X;
      OP_PASSY: z_next = Y;
      OP_LHI:   z_next = {Y[HALF-1:0], X[HALF-1:0]};
      default:  z_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z <= '0;
    end else begin
      z <= z_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed plus randomized scoreboard bench for the a4 ALU.
// Expected results are queued at issue and compared one clock later.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ALUop;
  logic [15:0] X;
  logic [15:0] Y;
  logic [15:0] z;

  sb_entry_t   sb[$];
  int          vectors = 0;
  int          fails   = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .ALUop (ALUop),
    .X     (X),
    .Y     (Y),
    .z     (z)
  );

  function automatic logic [15:0] ref_alu(input logic [4:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    logic [31:0] p;
    int unsigned n;
    n = (b > 16'd16) ? 16 : int'(b);
    r = a;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a + (~b) + 16'd1;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = ~a;
      5'd6:  r = (~a) + 16'd1;
      5'd7:  for (int unsigned i = 0; i < n; i++) r = {r[14:0], 1'b0};
      5'd8:  for (int unsigned i = 0; i < n; i++) r = {1'b0, r[15:1]};
      5'd9:  for (int unsigned i = 0; i < n; i++) r = {r[15], r[15:1]};
      5'd10: r = ((a ^ 16'h8000) < (b ^ 16'h8000)) ? 16'h0001 : 16'h0000;
      5'd11: r = (a < b) ? 16'h0001 : 16'h0000;
      5'd12: begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; end
      5'd13: r = a;
      5'd14: r = b;
      5'd15: r = {b[7:0], a[7:0]};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  task automatic check();
    sb_entry_t e;
    if (sb.size() == 0) begin
      vectors++;
      fails++;
      $error("FAIL scoreboard_empty: observed z=%h with no expected entry", z);
    end else begin
      e = sb.pop_front();
      vectors++;
      assert (z === e.exp) else begin
        fails++;
        $error("FAIL %s: z=%h expected %h", e.tag, z, e.exp);
      end
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [4:0] op,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    sb_entry_t e;
    reset = rst;
    ALUop = op;
    X     = a;
    Y     = b;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    logic [4:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;

    reset = 1'b1;
    ALUop = OP_ADD;
    X     = 16'hffff;
    Y     = 16'hffff;

    step("reset_c1",  1'b1, OP_ADD, 16'hffff, 16'hffff, 16'h0000);
    step("reset_c2",  1'b1, OP_ADD, 16'hffff, 16'hffff, 16'h0000);
    step("release",   1'b0, OP_ADD, 16'hffff, 16'hffff, 16'hfffe);

    step("add_ovf",   1'b0, OP_ADD,  16'h7fff, 16'h0001, 16'h8000);
    step("add_wrap",  1'b0, OP_ADD,  16'hffff, 16'h0001, 16'h0000);
    step("sub_wrap",  1'b0, OP_SUB,  16'h0000, 16'h0001, 16'hffff);
    step("neg_min",   1'b0, OP_NEG,  16'h8000, 16'h0000, 16'h8000);
    step("mul_low",   1'b0, OP_MUL,  16'h0100, 16'h0100, 16'h0000);
    step("mul_small", 1'b0, OP_MUL,  16'h0123, 16'h0011, 16'h1353);

    step("shl_15",    1'b0, OP_SHL,  16'h0001, 16'h000f, 16'h8000);
    step("shl_0",     1'b0, OP_SHL,  16'h1234, 16'h0000, 16'h1234);
    step("shl_16",    1'b0, OP_SHL,  16'hffff, 16'h0010, 16'h0000);
    step("shr_16",    1'b0, OP_SHR,  16'h8000, 16'h0010, 16'h0000);
    step("shr_3",     1'b0, OP_SHR,  16'h8000, 16'h0003, 16'h1000);
    step("sra_4",     1'b0, OP_SRA,  16'h8000, 16'h0004, 16'hf800);
    step("sra_32",    1'b0, OP_SRA,  16'h8000, 16'h0020, 16'hffff);
    step("sra_pos",   1'b0, OP_SRA,  16'h7000, 16'h0100, 16'h0000);

    step("slt_neg",   1'b0, OP_SLT,  16'hffff, 16'h0001, 16'h0001);
    step("sltu_big",  1'b0, OP_SLTU, 16'hffff, 16'h0001, 16'h0000);
    step("slt_eq",    1'b0, OP_SLT,  16'h0005, 16'h0005, 16'h0000);
    step("lhi",       1'b0, OP_LHI,  16'h12ab, 16'h00cd, 16'hcdab);
    step("passx",     1'b0, OP_PASSX,16'hbeef, 16'h1111, 16'hbeef);
    step("passy",     1'b0, OP_PASSY,16'hbeef, 16'h1111, 16'h1111);

    step("b2b_and",   1'b0, OP_AND,  16'hf0f0, 16'hff00, 16'hf000);
    step("b2b_or",    1'b0, OP_OR,   16'hf0f0, 16'hff00, 16'hfff0);
    step("b2b_xor",   1'b0, OP_XOR,  16'hf0f0, 16'hff00, 16'h0ff0);
    step("b2b_not",   1'b0, OP_NOT,  16'hf0f0, 16'hff00, 16'h0f0f);
    step("rsv_11111", 1'b0, 5'b11111,16'hffff, 16'hffff, 16'h0000);
    step("pre_rsv",   1'b0, OP_PASSX,16'ha5a5, 16'h0000, 16'ha5a5);
    step("rsv_10000", 1'b0, 5'b10000,16'ha5a5, 16'h0000, 16'h0000);
    step("pre_rst",   1'b0, OP_PASSX,16'h5a5a, 16'h0000, 16'h5a5a);
    step("rst_wins",  1'b1, OP_PASSX,16'h5a5a, 16'h0000, 16'h0000);

    for (int i = 0; i < 64; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      step("random", 1'b0, rop, ra, rb, ref_alu(rop, ra, rb));
    end

    vectors++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
